// File: rtl/pmem_write_buffer_if.sv
// Line-granular memory bus: one read/write request with a single-cycle
// response pulse. The requester uses the master modport, the responder
// uses the slave modport.
interface pmem_write_buffer_if;
    logic         read;
    logic         write;
    logic [15:0]  address;
    logic [127:0] wdata;
    logic [127:0] rdata;
    logic         resp;

    modport master (
        output read,
        output write,
        output address,
        output wdata,
        input  rdata,
        input  resp
    );

    modport slave (
        input  read,
        input  write,
        input  address,
        input  wdata,
        output rdata,
        output resp
    );
endinterface

// File: rtl/pmem_write_buffer.sv
// Single-entry write-back buffer between the cache's line port (cmem) and
// physical memory (pmem). Evictions are absorbed in one cycle, drained when
// the memory port is otherwise idle, and reads that hit the buffered line are
// forwarded from the buffer instead of going to memory.
module pmem_write_buffer (
    input  logic                        clk,
    input  logic                        rst_n,
    pmem_write_buffer_if.slave          cmem,
    pmem_write_buffer_if.master         pmem,
    output logic                        buf_valid
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_PMEM = 3'd1,
        RD_DONE = 3'd2,
        WR_DONE = 3'd3,
        DRAIN   = 3'd4
    } state_t;

    state_t        state_reg;

    // Buffered line and the latch that feeds cmem read data.
    logic [11:0]   buf_tag_reg;
    logic [127:0]  buf_data_reg;
    logic          buf_valid_reg;
    logic [127:0]  rd_data_reg;

    // Registered bus outputs; all of them clear asynchronously on reset.
    logic          cmem_resp_reg;
    logic          pmem_read_reg;
    logic          pmem_write_reg;
    logic [15:0]   pmem_address_reg;
    logic [127:0]  pmem_wdata_reg;

    // Request decode.
    logic [15:0]   line_address;
    logic          hit;

    // Line-aligned form of the cache address; also what a miss sends to pmem.
    assign line_address = cmem.address & 16'hFFF0;

    // A read or write targets the buffered line.
    assign hit = buf_valid_reg && (line_address[15:4] == buf_tag_reg);

    // Outputs come straight from registers so they drop the instant reset asserts.
    assign cmem.rdata    = rd_data_reg;
    assign cmem.resp     = cmem_resp_reg;
    assign pmem.read     = pmem_read_reg;
    assign pmem.write    = pmem_write_reg;
    assign pmem.address  = pmem_address_reg;
    assign pmem.wdata    = pmem_wdata_reg;
    assign buf_valid     = buf_valid_reg;

    // Controller: state, buffer storage and registered outputs in one block.
    // Outputs are loaded on the transition into the state that owns them and
    // cleared on the transition out, so they are exactly aligned with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            buf_tag_reg      <= '0;
            buf_data_reg     <= '0;
            buf_valid_reg    <= 1'b0;
            rd_data_reg      <= '0;
            cmem_resp_reg    <= 1'b0;
            pmem_read_reg    <= 1'b0;
            pmem_write_reg   <= 1'b0;
            pmem_address_reg <= '0;
            pmem_wdata_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cmem.read && hit) begin
                        // Forward the buffered line; memory is not touched.
                        rd_data_reg   <= buf_data_reg;
                        cmem_resp_reg <= 1'b1;
                        state_reg     <= RD_DONE;
                    end else if (cmem.read) begin
                        // Miss: fetch the line from memory. Read wins over a
                        // simultaneous write and over a pending drain.
                        pmem_read_reg    <= 1'b1;
                        pmem_address_reg <= line_address;
                        state_reg        <= RD_PMEM;
                    end else if (cmem.write && (!buf_valid_reg || hit)) begin
                        // Capture into an empty buffer, or coalesce onto the
                        // buffered line when the tags match.
                        buf_tag_reg   <= line_address[15:4];
                        buf_data_reg  <= cmem.wdata;
                        buf_valid_reg <= 1'b1;
                        cmem_resp_reg <= 1'b1;
                        state_reg     <= WR_DONE;
                    end else if (buf_valid_reg) begin
                        // Either a conflicting write needs the slot, or the
                        // port is idle: push the buffered line out. A waiting
                        // write is re-evaluated here once the drain completes.
                        pmem_write_reg   <= 1'b1;
                        pmem_address_reg <= {buf_tag_reg, 4'h0};
                        pmem_wdata_reg   <= buf_data_reg;
                        state_reg        <= DRAIN;
                    end else begin
                        state_reg <= IDLE;
                    end
                end

                RD_PMEM: begin
                    if (pmem.resp) begin
                        rd_data_reg      <= pmem.rdata;
                        pmem_read_reg    <= 1'b0;
                        pmem_address_reg <= '0;
                        cmem_resp_reg    <= 1'b1;
                        state_reg        <= RD_DONE;
                    end
                end

                RD_DONE, WR_DONE: begin
                    // One-cycle response; requests are not sampled here so a
                    // request still held this cycle is not accepted twice.
                    cmem_resp_reg <= 1'b0;
                    state_reg     <= IDLE;
                end

                DRAIN: begin
                    // Runs to completion; new requests wait until IDLE.
                    if (pmem.resp) begin
                        buf_valid_reg    <= 1'b0;
                        pmem_write_reg   <= 1'b0;
                        pmem_address_reg <= '0;
                        pmem_wdata_reg   <= '0;
                        state_reg        <= IDLE;
                    end
                end

                default: begin
                    cmem_resp_reg    <= 1'b0;
                    pmem_read_reg    <= 1'b0;
                    pmem_write_reg   <= 1'b0;
                    pmem_address_reg <= '0;
                    pmem_wdata_reg   <= '0;
                    state_reg        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pmem_write_buffer.sv
// Directed bench for pmem_write_buffer: each scenario drives the cache and
// memory sides cycle by cycle and compares against hand-derived values.
module tb_pmem_write_buffer;

    logic clk;
    logic rst_n;
    logic buf_valid;

    pmem_write_buffer_if cmem_bus ();
    pmem_write_buffer_if pmem_bus ();

    pmem_write_buffer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmem      (cmem_bus.slave),
        .pmem      (pmem_bus.master),
        .buf_valid (buf_valid)
    );

    localparam logic [127:0] D_A  = 128'hA0A1A2A3_A4A5A6A7_A8A9AAAB_ACADAEAF;
    localparam logic [127:0] D_B  = 128'hB0B1B2B3_B4B5B6B7_B8B9BABB_BCBDBEBF;
    localparam logic [127:0] D_C1 = 128'h11111111_22222222_33333333_44444444;
    localparam logic [127:0] D_C2 = 128'h55555555_66666666_77777777_88888888;
    localparam logic [127:0] D_3  = 128'h30303030_30303030_30303030_30303030;
    localparam logic [127:0] D_5  = 128'h50505050_50505050_50505050_50505050;
    localparam logic [127:0] D_6  = 128'h66666666_60606060_66666666_60606060;
    localparam logic [127:0] R_1  = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    localparam logic [127:0] R_2  = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;

    int n_cmp;
    int n_err;

    // Bus monitors, sampled on the falling edge.
    logic both_seen;
    logic pw_prev;
    int   n_pw_starts;
    int   n_cresp;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pmem_bus.read && pmem_bus.write) both_seen = 1'b1;
        if (pmem_bus.write && !pw_prev) n_pw_starts = n_pw_starts + 1;
        if (cmem_bus.resp) n_cresp = n_cresp + 1;
        pw_prev = pmem_bus.write;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    // Advance one cycle; outputs are then stable for sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic cache_idle();
        cmem_bus.read    = 1'b0;
        cmem_bus.write   = 1'b0;
        cmem_bus.address = 16'h0000;
        cmem_bus.wdata   = '0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_pr"}, pmem_bus.read, 1'b0);
        check({tag, "_pw"}, pmem_bus.write, 1'b0);
        check({tag, "_cr"}, cmem_bus.resp, 1'b0);
    endtask

    int pr_cycles;
    int starts0;
    int resp0;

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        both_seen   = 1'b0;
        pw_prev     = 1'b0;
        n_pw_starts = 0;
        n_cresp     = 0;
        rst_n       = 1'b0;
        cache_idle();
        pmem_bus.resp  = 1'b0;
        pmem_bus.rdata = '0;

        // ---- reset state ----
        #2;
        check_quiet("rst0");
        check("rst0_bv", buf_valid, 1'b0);
        check("rst0_addr", pmem_bus.address, 16'h0000);
        check("rst0_rdata", cmem_bus.rdata, 128'h0);
        ticks(2);
        rst_n = 1'b1;
        tick();

        // ---- write 0x1230, drain stalled, then read 0x123A ----
        cmem_bus.write = 1'b1; cmem_bus.address = 16'h1230; cmem_bus.wdata = D_A;
        tick();                                           // cycle 1
        check("a_wr_resp", cmem_bus.resp, 1'b1);
        check("a_bv", buf_valid, 1'b1);
        cache_idle();
        tick();                                           // cycle 2: IDLE
        check("a_c2_pw", pmem_bus.write, 1'b0);
        tick();                                           // cycle 3: DRAIN
        check("a_drain_pw", pmem_bus.write, 1'b1);
        check("a_drain_addr", pmem_bus.address, 16'h1230);
        check("a_drain_wdata", pmem_bus.wdata, D_A);
        cmem_bus.read = 1'b1; cmem_bus.address = 16'h123A;
        ticks(2);                                         // cycle 5, drain stalled
        check("a_stall_pw", pmem_bus.write, 1'b1);
        check("a_stall_pr", pmem_bus.read, 1'b0);
        check("a_stall_cr", cmem_bus.resp, 1'b0);
        pmem_bus.resp = 1'b1;
        tick();                                           // cycle 6: IDLE
        pmem_bus.resp = 1'b0;
        check("a_post_pw", pmem_bus.write, 1'b0);
        check("a_post_bv", buf_valid, 1'b0);
        tick();                                           // cycle 7: RD_PMEM
        check("a_miss_pr", pmem_bus.read, 1'b1);
        check("a_miss_addr", pmem_bus.address, 16'h1230);
        pmem_bus.resp = 1'b1; pmem_bus.rdata = R_1;
        tick();                                           // cycle 8: RD_DONE
        pmem_bus.resp = 1'b0;
        check("a_rd_resp", cmem_bus.resp, 1'b1);
        check("a_rd_data", cmem_bus.rdata, R_1);
        check("a_rd_pr", pmem_bus.read, 1'b0);
        cache_idle();
        tick();

        // ---- write then immediate read hit: forwarded ----
        cmem_bus.write = 1'b1; cmem_bus.address = 16'h1230; cmem_bus.wdata = D_B;
        tick();                                           // cycle 1
        check("b_wr_resp", cmem_bus.resp, 1'b1);
        cache_idle();
        tick();                                           // cycle 2: IDLE
        cmem_bus.read = 1'b1; cmem_bus.address = 16'h123A;
        tick();                                           // cycle 3: RD_DONE
        check("b_fwd_resp", cmem_bus.resp, 1'b1);
        check("b_fwd_data", cmem_bus.rdata, D_B);
        check("b_fwd_pr", pmem_bus.read, 1'b0);
        check("b_fwd_pw", pmem_bus.write, 1'b0);
        cache_idle();
        ticks(2);                                         // cycle 5: DRAIN
        check("b_drain_pw", pmem_bus.write, 1'b1);
        check("b_drain_wdata", pmem_bus.wdata, D_B);
        pmem_bus.resp = 1'b1;
        tick();
        pmem_bus.resp = 1'b0;
        check("b_bv", buf_valid, 1'b0);
        tick();

        // ---- read miss 0x4008, memory responds in cycle 5 ----
        cmem_bus.read = 1'b1; cmem_bus.address = 16'h4008;
        tick();                                           // cycle 1
        check("c_addr", pmem_bus.address, 16'h4000);
        pr_cycles = 0;
        for (int i = 1; i <= 5; i++) begin
            if (pmem_bus.read) pr_cycles++;
            check("c_early_cr", cmem_bus.resp, 1'b0);
            if (i == 5) begin
                pmem_bus.resp = 1'b1; pmem_bus.rdata = R_2;
            end
            tick();
        end                                               // cycle 6
        pmem_bus.resp = 1'b0;
        check("c_pr_cycles", pr_cycles, 5);
        check("c_resp", cmem_bus.resp, 1'b1);
        check("c_rdata", cmem_bus.rdata, R_2);
        check("c_pr_off", pmem_bus.read, 1'b0);
        cache_idle();
        tick();

        // ---- coalesce: 0x2000/D1 then 0x2004/D2 ----
        starts0 = n_pw_starts;
        resp0   = n_cresp;
        cmem_bus.write = 1'b1; cmem_bus.address = 16'h2000; cmem_bus.wdata = D_C1;
        tick();                                           // cycle 1
        cache_idle();
        tick();                                           // cycle 2: IDLE
        cmem_bus.write = 1'b1; cmem_bus.address = 16'h2004; cmem_bus.wdata = D_C2;
        tick();                                           // cycle 3: WR_DONE
        check("d_resp2", cmem_bus.resp, 1'b1);
        check("d_no_pw", pmem_bus.write, 1'b0);
        cache_idle();
        ticks(2);                                         // cycle 5: DRAIN
        check("d_drain_addr", pmem_bus.address, 16'h2000);
        check("d_drain_wdata", pmem_bus.wdata, D_C2);
        pmem_bus.resp = 1'b1;
        tick();
        pmem_bus.resp = 1'b0;
        ticks(4);
        check("d_pw_starts", n_pw_starts - starts0, 1);
        check("d_resps", n_cresp - resp0, 2);
        check_quiet("d_end");

        // ---- full buffer: 0x5000 arrives while 0x3000 drains ----
        cmem_bus.write = 1'b1; cmem_bus.address = 16'h3000; cmem_bus.wdata = D_3;
        tick();                                           // cycle 1
        cache_idle();
        ticks(2);                                         // cycle 3: DRAIN
        check("e_drain_addr", pmem_bus.address, 16'h3000);
        cmem_bus.write = 1'b1; cmem_bus.address = 16'h5000; cmem_bus.wdata = D_5;
        tick();                                           // cycle 4
        pmem_bus.resp = 1'b1;                             // pmem_resp in cycle 4
        tick();                                           // cycle 5: IDLE
        pmem_bus.resp = 1'b0;
        check("e_idle_cr", cmem_bus.resp, 1'b0);
        check("e_idle_pw", pmem_bus.write, 1'b0);
        check("e_idle_bv", buf_valid, 1'b0);
        tick();                                           // cycle 6: WR_DONE
        check("e_resp", cmem_bus.resp, 1'b1);
        check("e_bv", buf_valid, 1'b1);
        cache_idle();
        ticks(2);                                         // cycle 8: DRAIN
        check("e_drain2_addr", pmem_bus.address, 16'h5000);
        check("e_drain2_wdata", pmem_bus.wdata, D_5);
        pmem_bus.resp = 1'b1;
        tick();
        pmem_bus.resp = 1'b0;
        check("e_end_bv", buf_valid, 1'b0);
        tick();

        // ---- reset mid-DRAIN ----
        cmem_bus.write = 1'b1; cmem_bus.address = 16'h6000; cmem_bus.wdata = D_6;
        tick();
        cache_idle();
        ticks(2);                                         // DRAIN
        check("f_pw_before", pmem_bus.write, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("f_async_pw", pmem_bus.write, 1'b0);
        check("f_async_bv", buf_valid, 1'b0);
        check("f_async_addr", pmem_bus.address, 16'h0000);
        tick();
        rst_n = 1'b1;
        ticks(4);
        check_quiet("f_after");
        check("f_after_bv", buf_valid, 1'b0);

        // ---- reset mid-RD_PMEM, then a stray pmem_resp ----
        cmem_bus.read = 1'b1; cmem_bus.address = 16'h7010;
        tick();
        check("g_pr_before", pmem_bus.read, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("g_async_pr", pmem_bus.read, 1'b0);
        cache_idle();
        tick();
        rst_n = 1'b1;
        pmem_bus.resp = 1'b1; pmem_bus.rdata = R_1;
        tick();
        pmem_bus.resp = 1'b0;
        tick();
        check_quiet("g_stray");
        check("g_stray_rdata", cmem_bus.rdata, 128'h0);

        check("never_rd_and_wr", both_seen, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
